// File: rtl/sequenciador_ula_if.sv
// Request/status and datapath control-code bundle between the calculator front end,
// the sequencer and the X/Y/Z + ULA datapath.
interface sequenciador_ula_if;
  logic       start;
  logic [1:0] op;
  logic [2:0] n;
  logic       cancela;
  logic [1:0] auxX;
  logic [2:0] auxY;
  logic [1:0] auxZ;
  logic       auxULA;
  logic       ent_sel;
  logic       busy;
  logic       done;

  modport master (
    output start, op, n, cancela,
    input  auxX, auxY, auxZ, auxULA, ent_sel, busy, done
  );

  modport slave (
    input  start, op, n, cancela,
    output auxX, auxY, auxZ, auxULA, ent_sel, busy, done
  );
endinterface

// File: rtl/sequenciador_ula.sv
// Moore sequencer driving X/Y/Z/ULA control codes for one ADD/SUB/SHL/SHR request at a time.
// Done 4 cycles after the start edge (4+n for shifts); start is ignored while busy, cancela aborts.
module sequenciador_ula (
  input  logic              clk,
  input  logic              reset,
  sequenciador_ula_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    CARGA_X,
    CARGA_Y,
    DESLOCA,
    GRAVA,
    FIM
  } estado_t;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;

  estado_t    estado, prox;
  logic [1:0] op_r, op_nx;
  logic [2:0] cont, cont_nx;
  logic       desloc;

  // Both shift opcodes have the MSB set.
  assign desloc = op_r[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= IDLE;
      op_r   <= 2'b00;
      cont   <= 3'd0;
    end else begin
      estado <= prox;
      op_r   <= op_nx;
      cont   <= cont_nx;
    end
  end

  always_comb begin
    prox        = estado;
    op_nx       = op_r;
    cont_nx     = cont;
    bus.auxX    = 2'b10;
    bus.auxY    = 3'b010;
    bus.auxZ    = 2'b10;
    bus.auxULA  = 1'b0;
    bus.ent_sel = 1'b0;
    bus.done    = 1'b0;
    bus.busy    = (estado != IDLE);

    case (estado)
      IDLE: begin
        if (bus.start) begin
          prox    = CARGA_X;
          op_nx   = bus.op;
          cont_nx = bus.n;
        end
      end
      CARGA_X: begin
        // Shifts clear X so the ULA sum passes Y straight through to Z.
        bus.auxX = desloc ? 2'b00 : 2'b01;
        prox     = CARGA_Y;
      end
      CARGA_Y: begin
        bus.auxY    = 3'b001;
        bus.ent_sel = 1'b1;
        prox        = (desloc && cont != 3'd0) ? DESLOCA : GRAVA;
      end
      DESLOCA: begin
        bus.auxY = (op_r == OP_SHL) ? 3'b011 : 3'b100;
        cont_nx  = cont - 3'd1;
        if (cont == 3'd1) prox = GRAVA;
      end
      GRAVA: begin
        bus.auxZ   = 2'b01;
        bus.auxULA = (op_r == OP_SUB);
        prox       = FIM;
      end
      FIM: begin
        bus.done = 1'b1;
        prox     = IDLE;
      end
      default: prox = IDLE;
    endcase

    if (estado != IDLE && bus.cancela) prox = IDLE;
  end
endmodule

// File: tb/tb_sequenciador_ula.sv
// Bench for sequenciador_ula: an 8-bit X/Y/Z datapath follows the control codes, and a
// scoreboard of spec-level results (Z value, latency, code counts) is checked on each done.
module tb_sequenciador_ula;
  logic clk = 1'b0;
  logic reset;

  sequenciador_ula_if bus ();

  sequenciador_ula dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] z;
    int         lat;
    int         nshl;
    int         nshr;
    int         nclr;
    int         sub;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam int IDLE_CODES = 10'b10_010_10_0_0_0;
  localparam int FIM_CODES  = 9'b10_010_10_0_0;

  logic [7:0] cur_a = 8'd0;
  logic [7:0] cur_b = 8'd0;
  logic [7:0] rx = 8'd0;
  logic [7:0] ry = 8'd0;
  logic [7:0] rz = 8'd0;
  logic [7:0] dbus;

  assign dbus = bus.ent_sel ? cur_b : cur_a;

  // Datapath: X/Y/Z registers obeying the control codes, bus carrying A or B.
  always @(posedge clk) begin
    case (bus.auxX)
      2'b00:   rx <= 8'd0;
      2'b01:   rx <= dbus;
      default: rx <= rx;
    endcase
    case (bus.auxY)
      3'b000:  ry <= 8'd0;
      3'b001:  ry <= dbus;
      3'b011:  ry <= ry << 1;
      3'b100:  ry <= ry >> 1;
      default: ry <= ry;
    endcase
    case (bus.auxZ)
      2'b00:   rz <= 8'd0;
      2'b01:   rz <= bus.auxULA ? (rx - ry) : (rx + ry);
      default: rz <= rz;
    endcase
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [2:0] c,
                                 input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [7:0] r;
    int sh;
    sh = int'(c);
    case (o)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = b << c;
      default: r = b >> c;
    endcase
    e.z    = r;
    e.lat  = (o == 2'b10 || o == 2'b11) ? 4 + sh : 4;
    e.nshl = (o == 2'b10) ? sh : 0;
    e.nshr = (o == 2'b11) ? sh : 0;
    e.nclr = (o == 2'b10 || o == 2'b11) ? 1 : 0;
    e.sub  = (o == 2'b01) ? 1 : 0;
    return e;
  endfunction

  // Monitor: idle codes every idle cycle, full transaction check on each done.
  initial begin
    bit   in_txn;
    int   cyc, nshl, nshr, nclr, nz, ula_g;
    exp_t e;
    in_txn = 0;
    cyc = 0; nshl = 0; nshr = 0; nclr = 0; nz = 0; ula_g = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy) begin
        in_txn = 0;
        check("idle_codes", int'({bus.auxX, bus.auxY, bus.auxZ, bus.auxULA, bus.ent_sel, bus.done}),
              IDLE_CODES);
      end else begin
        if (!in_txn) begin
          in_txn = 1;
          cyc = 0; nshl = 0; nshr = 0; nclr = 0; nz = 0; ula_g = 0;
        end
        cyc++;
        if (bus.auxY == 3'b011) nshl++;
        if (bus.auxY == 3'b100) nshr++;
        if (bus.auxX == 2'b00) nclr++;
        if (bus.auxZ == 2'b01) begin
          nz++;
          ula_g = int'(bus.auxULA);
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: done seen with empty scoreboard at %0t", $time);
          end else begin
            e = sb.pop_front();
            check("z_result", int'(rz), int'(e.z));
            check("latency", cyc, e.lat);
            check("shl_cycles", nshl, e.nshl);
            check("shr_cycles", nshr, e.nshr);
            check("x_clear_cycles", nclr, e.nclr);
            check("z_load_cycles", nz, 1);
            check("ula_sub", ula_g, e.sub);
            check("fim_codes", int'({bus.auxX, bus.auxY, bus.auxZ, bus.auxULA, bus.ent_sel}),
                  FIM_CODES);
          end
        end
      end
    end
  end

  // Waits for an idle negedge, then strobes start across one rising edge.
  task automatic issue(input logic [1:0] o, input logic [2:0] c,
                       input logic [7:0] a, input logic [7:0] b, input bit track);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.busy && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (bus.busy) check("wait_idle_timeout", 1, 0);
    cur_a     = a;
    cur_b     = b;
    bus.op    = o;
    bus.n     = c;
    bus.start = 1'b1;
    if (track) sb.push_back(model(o, c, a, b));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (bus.busy && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (bus.busy) check("drain_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ro;
    logic [2:0] rn;
    logic [7:0] ra, rb;
    int w;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.n       = 3'd0;
    bus.cancela = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    reset = 1'b0;

    issue(2'b00, 3'd0, 8'd9, 8'd3, 1);
    issue(2'b01, 3'd0, 8'd9, 8'd3, 1);
    issue(2'b10, 3'd3, 8'h5a, 8'h01, 1);
    issue(2'b11, 3'd0, 8'h33, 8'h05, 1);
    issue(2'b11, 3'd7, 8'h11, 8'h80, 1);

    // Asynchronous reset in the middle of a shift sequence.
    issue(2'b10, 3'd5, 8'h00, 8'h01, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_codes",
          int'({bus.auxX, bus.auxY, bus.auxZ, bus.auxULA, bus.ent_sel, bus.done}), IDLE_CODES);
    check("async_reset_busy", int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    issue(2'b00, 3'd4, 8'd100, 8'd27, 1);

    // start held high for the whole busy window must not retrigger.
    issue(2'b00, 3'd0, 8'd40, 8'd2, 1);
    bus.start = 1'b1;
    w = 0;
    @(negedge clk);
    while (bus.busy && w < 60) begin
      @(negedge clk);
      w++;
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("held_start_ignored", int'(bus.busy), 0);

    // Abort while in CARGA_Y: no done, idle next cycle.
    issue(2'b01, 3'd0, 8'd7, 8'd1, 0);
    @(posedge clk);
    #1 bus.cancela = 1'b1;
    @(posedge clk);
    #1 bus.cancela = 1'b0;
    check("cancel_busy", int'(bus.busy), 0);
    check("cancel_codes",
          int'({bus.auxX, bus.auxY, bus.auxZ, bus.auxULA, bus.ent_sel, bus.done}), IDLE_CODES);
    issue(2'b01, 3'd2, 8'd50, 8'd60, 1);

    // start together with cancela in IDLE: start wins.
    wait_idle();
    bus.cancela = 1'b1;
    issue(2'b10, 3'd2, 8'd0, 8'h21, 1);
    bus.cancela = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rn = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ro, rn, ra, rb, 1);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
